// File: rtl/mprj_pad_config_loader.sv
// mprj_pad_config_loader: fetches one config word per pad from the register bank and
// shifts it MSB-first into the pad control chain, then strobes serial_load to latch all pads.
module mprj_pad_config_loader #(
    parameter int PADS     = 38,
    parameter int ADDR_W   = 6,
    parameter int CFG_BITS = 10,
    parameter int CLK_DIV  = 1
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic                xfer_start,
    input  logic                xfer_abort,
    output logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_rdata,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                busy,
    output logic                done
);
    localparam int BW = $clog2(CFG_BITS + 1);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PADS - 1);
    localparam logic [BW-1:0]     NBITS = BW'(CFG_BITS);
    localparam logic [CW-1:0]     DIV   = CW'(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_LOAD, S_FIN} state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   pad_cnt, pad_d, addr_d;
    logic [BW-1:0]       bit_cnt, bit_d;
    logic [CW-1:0]       ph_cnt, ph_d;
    logic                hi, hi_d;
    logic [CFG_BITS-1:0] sr, sr_d;
    logic                sclk_d, sdata_d, load_d, busy_d, done_d;
    logic                ph_end, last_bit;

    assign ph_end   = ph_cnt == CW'(1);
    assign last_bit = bit_cnt == BW'(1);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = (xfer_start && !xfer_abort) ? S_FETCH : S_IDLE;
            S_FETCH: state_d = xfer_abort ? S_IDLE : hi ? S_SHIFT : S_FETCH;
            S_SHIFT: state_d = xfer_abort ? S_IDLE :
                               !(ph_end && hi && last_bit) ? S_SHIFT :
                               (pad_cnt == '0) ? S_LOAD : S_FETCH;
            S_LOAD:  state_d = xfer_abort ? S_IDLE : (ph_end && hi) ? S_FIN : S_LOAD;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of every registered output and counter; hi marks the second half of
    // FETCH, the high phase of a bit in SHIFT, and the low half of the strobe in LOAD.
    always_comb begin
        addr_d  = cfg_addr;
        pad_d   = pad_cnt;
        bit_d   = bit_cnt;
        ph_d    = ph_cnt;
        hi_d    = hi;
        sr_d    = sr;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        load_d  = 1'b0;
        busy_d  = state_d != S_IDLE;
        done_d  = state_d == S_FIN;
        case (state)
            S_IDLE: if (state_d == S_FETCH) begin
                pad_d  = LAST;
                addr_d = LAST;
                hi_d   = 1'b0;
            end
            S_FETCH: if (state_d == S_SHIFT) begin
                sr_d    = cfg_rdata;
                sdata_d = cfg_rdata[CFG_BITS-1];
                bit_d   = NBITS;
                ph_d    = DIV;
                hi_d    = 1'b0;
            end else begin
                hi_d = 1'b1;
            end
            S_SHIFT: if (!xfer_abort) begin
                sclk_d  = hi;
                sdata_d = serial_data;
                ph_d    = ph_end ? DIV : ph_cnt - CW'(1);
                if (ph_end && !hi) begin
                    hi_d   = 1'b1;
                    sclk_d = 1'b1;
                end else if (ph_end) begin
                    hi_d   = 1'b0;
                    sclk_d = 1'b0;
                    if (!last_bit) begin
                        bit_d   = bit_cnt - BW'(1);
                        sr_d    = sr << 1;
                        sdata_d = sr_d[CFG_BITS-1];
                    end else begin
                        sdata_d = 1'b0;
                        load_d  = state_d == S_LOAD;
                        if (state_d == S_FETCH) begin
                            pad_d  = pad_cnt - ADDR_W'(1);
                            addr_d = pad_cnt - ADDR_W'(1);
                        end
                    end
                end
            end
            S_LOAD: if (!xfer_abort) begin
                ph_d   = ph_end ? DIV : ph_cnt - CW'(1);
                load_d = !hi && !ph_end;
                if (ph_end) hi_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cfg_addr     <= '0;
            pad_cnt      <= '0;
            bit_cnt      <= '0;
            ph_cnt       <= '0;
            hi           <= 1'b0;
            sr           <= '0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            cfg_addr     <= addr_d;
            pad_cnt      <= pad_d;
            bit_cnt      <= bit_d;
            ph_cnt       <= ph_d;
            hi           <= hi_d;
            sr           <= sr_d;
            serial_clock <= sclk_d;
            serial_data  <= sdata_d;
            serial_load  <= load_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end
endmodule
